sram_like_arbiter: RTL
======================

# sram_like_arbiter

Two-master arbiter that merges the CPU's instruction-fetch and data-access SRAM-like ports onto a single SRAM-like port feeding the AXI bridge. It sits between the pipeline and the bridge. It performs fixed-priority grant with request locking, and tracks up to MAX_OUTSTANDING in-flight transactions so that each in-order downstream data_ok is routed back to the originating master.

## Interface

- MAX_OUTSTANDING, 4: maximum accepted-but-unanswered transactions; power of 2, at least 2.
- CNT_W, log2(MAX_OUTSTANDING)+1: width of the outstanding count.

Ports:

- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- inst_req, inst_wr  in  1 each  instruction master request and write flag.
- inst_size  in  2  instruction master access size.
- inst_addr, inst_wdata  in  32 each  instruction master address and write data.
- inst_rdata  out  32  read data returned to the instruction master.
- inst_addr_ok, inst_data_ok  out  1 each  address and data handshakes to the instruction master.
- data_req, data_wr, data_size, data_addr, data_wdata, data_rdata, data_addr_ok, data_data_ok: same widths and meanings as inst_*, for the data master.
- mem_req, mem_wr  out  1 each  downstream request and write flag.
- mem_size  out  2  downstream access size.
- mem_addr, mem_wdata  out  32 each  downstream address and write data.
- mem_rdata  in  32  downstream read data.
- mem_addr_ok, mem_data_ok  in  1 each  downstream handshakes; the downstream answers strictly in acceptance order.
- outstanding  out  CNT_W  current number of in-flight transactions.

## Operation

**Grant selection**
- Data has fixed priority over inst whenever neither grant is locked.
- sel = locked ? lock_src : (data_req ? DATA : INST).

**Grant lock**
- Lock is set when mem_req=1 and mem_addr_ok=0; lock_src captures sel.
- Lock clears on mem_addr_ok=1.
- Lock also clears if the locked master drops its req (protocol violation tolerated). The next cycle then re-arbitrates.
- The lock keeps mem_addr, mem_wr, mem_size and mem_wdata stable until the downstream accepts.

**Downstream request**
- mem_req = sel_req & !full & !reset.
- mem_wr, mem_size, mem_addr and mem_wdata are muxed from the selected master.

**Address handshake back to masters**
- inst_addr_ok = mem_addr_ok & mem_req & (sel==INST).
- data_addr_ok = mem_addr_ok & mem_req & (sel==DATA).
- The non-selected master never sees addr_ok.

**Tag FIFO**
- Depth MAX_OUTSTANDING, 1-bit source tag per entry.
- Push sel on mem_req & mem_addr_ok.
- Pop on mem_data_ok & !empty.
- Push and pop may occur in the same cycle; count is then unchanged.
- full = (count==MAX_OUTSTANDING). Pointers wrap modulo MAX_OUTSTANDING.
- outstanding = count.

**Data return**
- inst_data_ok = mem_data_ok & !empty & (head==INST).
- data_data_ok = mem_data_ok & !empty & (head==DATA).
- inst_rdata = data_rdata = mem_rdata, broadcast to both.

**Boundary cases**
- mem_data_ok while empty is dropped: no pop, no data_ok to either master.
- When full, mem_req=0 even if requests are pending. A pop in that cycle does not unblock the same cycle; mem_req rises the next cycle.
- Writes occupy a FIFO entry exactly like reads.

## Timing

- Reset values: lock=0, FIFO empty, pointers 0, outstanding=0. While reset is high, mem_req, both addr_ok and both data_ok are 0.
- Reset mid-operation discards all in-flight tags. The downstream is reset alongside the arbiter.
- Request path is combinational, zero added latency: master req to mem_req in the same cycle.
- Response path is combinational: mem_data_ok to master data_ok in the same cycle.
- Registered state: lock, lock_src, FIFO contents, pointers and count.
- Sustained throughput is one accepted request per cycle while not full.
- A master may have its next request accepted in the same cycle its previous data_ok returns.

## Test plan

- Both inst_req and data_req high from an idle state, mem_addr_ok=1 -> data granted first (data_addr_ok=1, mem_addr=data_addr); inst granted the next cycle; outstanding goes 0→1→2.
- inst_req alone with mem_addr_ok=0 for 3 cycles, data_req rising in cycle 2 -> mem_addr stays inst_addr throughout; inst_addr_ok on accept; data granted the following cycle.
- Accept 4 requests back-to-back (MAX_OUTSTANDING=4) with no data_ok -> outstanding=4 and mem_req=0 while requests remain. One mem_data_ok -> mem_req=1 the next cycle.
- Accepted order D, I, D, then three mem_data_ok pulses with rdata 0x11, 0x22, 0x33 -> data_data_ok with 0x11, inst_data_ok with 0x22, data_data_ok with 0x33; outstanding returns to 0.
- mem_data_ok pulse while empty -> no master data_ok; outstanding stays 0.
- Reset asserted with 2 outstanding -> next cycle outstanding=0, mem_req=0. A later mem_data_ok produces no master data_ok.

Source files
------------

// File: rtl/sram_like_arbiter_if.sv
// One SRAM-like channel: request/address phase from master, addr_ok/data_ok/rdata from slave.
interface sram_like_arbiter_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              addr_ok;
    logic              data_ok;

    modport master (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// Merges inst and data SRAM-like masters onto one downstream port; a tag FIFO
// routes each in-order downstream data_ok back to the master that issued it.
module sram_like_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    sram_like_arbiter_if.slave         inst,
    sram_like_arbiter_if.slave         data,
    sram_like_arbiter_if.master        mem,
    output logic [CNT_W-1:0]           outstanding
);
    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    logic             locked_q;
    src_e             lock_src_q;
    src_e             sel;
    logic             sel_req;
    src_e             tag_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    src_e             head;

    // Data wins unless an unaccepted request holds the grant.
    always_comb begin
        sel = data.req ? SRC_DATA : SRC_INST;
        if (locked_q) begin
            sel = lock_src_q;
        end
        sel_req = (sel == SRC_DATA) ? data.req : inst.req;
    end

    assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign empty = (count_q == '0);
    assign head  = tag_q[rd_ptr_q];

    always_comb begin
        mem.req   = sel_req & ~full & ~reset;
        mem.wr    = (sel == SRC_DATA) ? data.wr    : inst.wr;
        mem.size  = (sel == SRC_DATA) ? data.size  : inst.size;
        mem.addr  = (sel == SRC_DATA) ? data.addr  : inst.addr;
        mem.wdata = (sel == SRC_DATA) ? data.wdata : inst.wdata;
    end

    assign push = mem.req & mem.addr_ok;
    assign pop  = mem.data_ok & ~empty & ~reset;

    always_comb begin
        inst.addr_ok = push & (sel == SRC_INST);
        data.addr_ok = push & (sel == SRC_DATA);
        inst.data_ok = pop & (head == SRC_INST);
        data.data_ok = pop & (head == SRC_DATA);
        inst.rdata   = mem.rdata;
        data.rdata   = mem.rdata;
    end

    assign outstanding = count_q;

    // A dropped req on the locked master leaves mem.req low, so the lock falls away.
    always_ff @(posedge clk) begin
        if (reset) begin
            locked_q   <= 1'b0;
            lock_src_q <= SRC_INST;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            locked_q <= mem.req & ~mem.addr_ok;
            if (mem.req & ~mem.addr_ok) begin
                lock_src_q <= sel;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Tag storage needs no reset; validity comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[wr_ptr_q] <= sel;
        end
    end
endmodule
